// File: rtl/multdiv_unit.sv
// Iterative 32-bit signed multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one iteration per clock over 32 cycles.
//
// state | meaning
// IDLE  | waiting for a start pulse
// RUN   | 32 iterations in flight, busy asserted
// DONE  | result/exception valid, data_ready asserted for one cycle
module multdiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_mult,
    input  logic        ctrl_div,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    output logic [31:0] result,
    output logic        exception,
    output logic        data_ready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic        is_mult;
    logic        neg;
    logic [31:0] op_b;
    logic [32:0] acc_hi;
    logic [31:0] acc_lo;

    logic        start, div_zero, fin;
    logic [31:0] mag_a, mag_b;
    logic [32:0] add_sum, hi_sel, rem_sh, diff;
    logic [64:0] shifted;
    logic [32:0] hi_nxt;
    logic [31:0] lo_nxt;
    logic [63:0] prod_mag, prod;
    logic [31:0] quo;
    logic [31:0] res_fin;
    logic        exc_fin;

    always_comb begin
        start     = (state != RUN) && (ctrl_mult || ctrl_div);
        div_zero  = start && !ctrl_mult && (data_b == 32'd0);
        fin       = (state == RUN) && (cnt == 6'd31);
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = div_zero ? DONE : RUN;
            RUN:     if (fin) state_nxt = DONE;
            DONE:    state_nxt = start ? (div_zero ? DONE : RUN) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        mag_a = data_a[31] ? -data_a : data_a;
        mag_b = data_b[31] ? -data_b : data_b;

        // multiply: conditional add of the multiplicand, then shift {hi,lo} right
        add_sum = acc_hi + {1'b0, op_b};
        hi_sel  = acc_lo[0] ? add_sum : acc_hi;
        shifted = {hi_sel, acc_lo} >> 1;

        // divide: remainder stays below the divisor, so bit 32 of diff is a valid borrow
        rem_sh  = {acc_hi[31:0], acc_lo[31]};
        diff    = rem_sh - {1'b0, op_b};

        if (is_mult) begin
            hi_nxt = shifted[64:32];
            lo_nxt = shifted[31:0];
        end else if (!diff[32]) begin
            hi_nxt = diff;
            lo_nxt = {acc_lo[30:0], 1'b1};
        end else begin
            hi_nxt = rem_sh;
            lo_nxt = {acc_lo[30:0], 1'b0};
        end

        prod_mag = {hi_nxt[31:0], lo_nxt};
        prod     = neg ? -prod_mag : prod_mag;
        quo      = neg ? -lo_nxt : lo_nxt;

        if (is_mult) begin
            res_fin = prod[31:0];
            exc_fin = prod[63:32] != {32{prod[31]}};
        end else begin
            res_fin = quo;
            exc_fin = !neg && lo_nxt[31];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            is_mult   <= 1'b0;
            neg       <= 1'b0;
            op_b      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            result    <= '0;
            exception <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            is_mult <= ctrl_mult;
            neg     <= data_a[31] ^ data_b[31];
            op_b    <= ctrl_mult ? mag_a : mag_b;
            acc_hi  <= '0;
            acc_lo  <= ctrl_mult ? mag_b : mag_a;
            if (div_zero) begin
                result    <= '0;
                exception <= 1'b1;
            end
        end else if (state == RUN) begin
            cnt    <= cnt + 6'd1;
            acc_hi <= hi_nxt;
            acc_lo <= lo_nxt;
            if (fin) begin
                result    <= res_fin;
                exception <= exc_fin;
            end
        end
    end

    assign data_ready = (state == DONE);
    assign busy       = (state == RUN);

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: vector table plus sequences for
// back-to-back starts, starts ignored during RUN and reset aborting RUN.
module tb_multdiv_unit;

    logic        clk;
    logic        reset;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [31:0] result;
    logic        exception;
    logic        data_ready;
    logic        busy;

    multdiv_unit dut (
        .clk(clk), .reset(reset), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .data_a(data_a), .data_b(data_b), .result(result), .exception(exception),
        .data_ready(data_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;   // 0 mult, 1 div, 2 both strobes high
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    vec_t        vecs[15];
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_res = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // scoreboard side: every data_ready pops one expectation; result must hold while busy
    always @(negedge clk) begin
        if (!reset) begin
            last_res = '0;
        end else begin
            if (busy) check("result_hold_in_run", result, last_res);
            if (data_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_data_ready: got result 0x%08h with no pending op", result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("exception", {31'd0, exception}, {31'd0, e.exc});
                end
                last_res = result;
            end
        end
    end

    // called at a negedge; strobes are sampled by the following posedge
    task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        ctrl_mult = (op != 2'd1);
        ctrl_div  = (op != 2'd0);
        data_a    = a;
        data_b    = b;
        @(negedge clk);
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        data_a    = $urandom;
        data_b    = $urandom;
    endtask

    task automatic wait_ready(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!data_ready && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic exc);
        int lat, bcnt, exp_lat;
        exp_lat = (op == 2'd1 && b == 32'd0) ? 0 : 32;
        sb.push_back('{res, exc});
        drive_start(op, a, b);
        wait_ready(lat, bcnt);
        check("latency", lat, exp_lat);
        check("busy_cycles", bcnt, exp_lat);
    endtask

    initial begin
        int lat, bcnt;

        vecs[0]  = '{2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
        vecs[2]  = '{2'd0, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
        vecs[3]  = '{2'd1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[5]  = '{2'd0, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 1'b0};
        vecs[6]  = '{2'd1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[7]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[8]  = '{2'd0, 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1};
        vecs[9]  = '{2'd0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[10] = '{2'd1, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
        vecs[11] = '{2'd1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 1'b0};
        vecs[12] = '{2'd1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[13] = '{2'd1, 32'h1234_5678, 32'h0000_1000, 32'h0001_2345, 1'b0};
        vecs[14] = '{2'd2, 32'h0000_0006, 32'h0000_0000, 32'h0000_0000, 1'b0};

        reset     = 1'b0;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        data_a    = '0;
        data_b    = '0;
        repeat (2) @(negedge clk);
        check("reset_result", result, 32'd0);
        check("reset_exception", {31'd0, exception}, 32'd0);
        check("reset_data_ready", {31'd0, data_ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc);
            @(negedge clk);
        end

        // back-to-back: new start presented during the DONE cycle
        sb.push_back('{32'hFFFF_FFEB, 1'b0});
        drive_start(2'd0, 32'h0000_0007, 32'hFFFF_FFFD);
        wait_ready(lat, bcnt);
        check("b2b_first_latency", lat, 32);
        run_op(2'd1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0);
        @(negedge clk);

        // divide-by-zero strobe 10 cycles into a multiply must be ignored
        sb.push_back('{32'hFFFF_EC78, 1'b0});
        drive_start(2'd0, 32'd1000, 32'hFFFF_FFFB);
        repeat (9) @(negedge clk);
        ctrl_div = 1'b1;
        data_a   = 32'd9;
        data_b   = 32'd0;
        @(negedge clk);
        ctrl_div = 1'b0;
        wait_ready(lat, bcnt);
        check("ignored_start_latency", lat, 22);
        check("ignored_start_busy", bcnt, 22);
        @(negedge clk);

        // reset 10 cycles into RUN aborts with no data_ready
        sb.push_back('{32'h0000_0063, 1'b0});
        drive_start(2'd0, 32'd9, 32'd11);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        sb.delete();
        check("abort_result", result, 32'd0);
        check("abort_exception", {31'd0, exception}, 32'd0);
        check("abort_data_ready", {31'd0, data_ready}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_pending", sb.size(), 0);
        run_op(2'd0, 32'd9, 32'd11, 32'd99, 1'b0);
        @(negedge clk);

        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
